// File: rtl/srl_fifo_pkg.sv
// Shared defaults and sizing helpers for the addressable shift-register FIFO.
package srl_fifo_pkg;

    localparam int unsigned SRL_DEFAULT_WIDTH = 8;
    localparam int unsigned SRL_DEFAULT_DEPTH = 4;

    // The tap address needs at least one bit, even for the smallest store.
    function automatic int unsigned addr_bits(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/srl_fifo_store.sv
// Addressable shift register: new words enter at index 0, and any stored word
// can be read combinationally by tap address.
module ShiftRegAddr
    import srl_fifo_pkg::*;
#(
    parameter int unsigned Width = SRL_DEFAULT_WIDTH,
    parameter int unsigned Depth = SRL_DEFAULT_DEPTH,
    parameter int unsigned AddrW = addr_bits(Depth)
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic [Width-1:0] d_i,
    input  logic [AddrW-1:0] addr_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];

    always_comb begin
        mem_d = mem_q;
        if (en_i) begin
            mem_d[0] = d_i;
            for (int unsigned i = 1; i < Depth; i++) begin
                mem_d[i] = mem_q[i-1];
            end
        end
    end

    // Contents are intentionally left unreset; only addresses below the
    // controller's count are ever consumed.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_comb begin
        q_o = '0;
        if (32'(addr_i) < Depth) begin
            q_o = mem_q[addr_i];
        end
    end

endmodule

// File: rtl/srl_fifo.sv
// Elastic FIFO: shift-register store plus a registered output stage, with a
// bypass so a word written into an empty FIFO appears after a single edge.
module srl_fifo
    import srl_fifo_pkg::*;
#(
    parameter int unsigned Width = SRL_DEFAULT_WIDTH,
    parameter int unsigned Depth = SRL_DEFAULT_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       s_valid_i,
    output logic                       s_ready_o,
    input  logic [Width-1:0]           s_data_i,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic [Width-1:0]           m_data_o,
    output logic [$clog2(Depth+2)-1:0] count_o
);

    localparam int unsigned CntW  = $clog2(Depth + 1);
    localparam int unsigned OutW  = $clog2(Depth + 2);
    localparam int unsigned AddrW = addr_bits(Depth);

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [Width-1:0] out_data_q, out_data_d;

    logic             store_empty;
    logic             store_full;
    logic             push;
    logic             load;
    logic             shift_in;
    logic             shift_out;
    logic             store_en;
    logic [AddrW-1:0] tap_addr;
    logic [Width-1:0] tap_data;

    ShiftRegAddr #(
        .Width (Width),
        .Depth (Depth),
        .AddrW (AddrW)
    ) u_store (
        .clk_i  (clk_i),
        .en_i   (store_en),
        .d_i    (s_data_i),
        .addr_i (tap_addr),
        .q_o    (tap_data)
    );

    always_comb begin
        store_empty = (cnt_q == '0);
        store_full  = (cnt_q == CntW'(Depth));
        push        = s_valid_i & ~store_full;
        load        = (~out_valid_q | m_ready_i) & (~store_empty | push);
        // A word written while the store is empty and the output stage can
        // take it goes straight to the output register and never shifts in.
        shift_in    = push & ~(load & store_empty);
        shift_out   = load & ~store_empty;
        store_en    = shift_in & ~rst_i;
        tap_addr    = AddrW'(cnt_q - CntW'(1));

        cnt_d = cnt_q;
        if (shift_in && !shift_out) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (shift_out && !shift_in) begin
            cnt_d = cnt_q - CntW'(1);
        end

        out_valid_d = load | (out_valid_q & ~m_ready_i);
        out_data_d  = out_data_q;
        if (load) begin
            out_data_d = store_empty ? s_data_i : tap_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign s_ready_o = ~store_full;
    assign m_valid_o = out_valid_q;
    assign m_data_o  = out_data_q;
    assign count_o   = OutW'(cnt_q) + OutW'(out_valid_q);

endmodule

// File: tb/tb_srl_fifo.sv
// Directed and randomized checks of srl_fifo against a queue-based model of a
// Depth+1 entry in-order buffer.
module tb_srl_fifo;

    localparam int unsigned W   = 8;
    localparam int unsigned D   = 4;
    localparam int unsigned CAP = D + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic [2:0]   count;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [W-1:0] mq[$];

    srl_fifo #(
        .Width (W),
        .Depth (D)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .s_data_i  (s_data),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .m_data_o  (m_data),
        .count_o   (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("m_valid", 32'(m_valid), 32'(mq.size() > 0));
        chk("count", 32'(count), 32'(mq.size()));
        chk("s_ready", 32'(s_ready), 32'(mq.size() < CAP));
        if (mq.size() > 0) chk("m_data", 32'(m_data), 32'(mq[0]));
    endtask

    // One clock: the model decides acceptance from the pre-edge state, then
    // outputs are compared 1 time unit after the edge.
    task automatic cyc();
        bit pop_now;
        bit acc_now;
        pop_now = (mq.size() > 0) && m_ready;
        acc_now = s_valid && (mq.size() < CAP);
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
        end else begin
            if (pop_now) void'(mq.pop_front());
            if (acc_now) mq.push_back(s_data);
        end
        check_model();
    endtask

    initial begin
        bit did_rst;
        rst = 1'b1; s_valid = 1'b1; s_data = 8'h77; m_ready = 1'b0;

        // Reset with a write offered: nothing may be taken.
        cyc();
        cyc();
        chk("rst_m_data", 32'(m_data), 32'h00);
        chk("rst_count", 32'(count), 32'd0);
        rst = 1'b0; s_valid = 1'b0;
        cyc();
        chk("post_rst_count", 32'(count), 32'd0);

        // Bypass into empty, then stall.
        s_valid = 1'b1; s_data = 8'hA5;
        cyc();
        s_valid = 1'b0;
        chk("bypass_valid", 32'(m_valid), 32'd1);
        chk("bypass_data", 32'(m_data), 32'hA5);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_data", 32'(m_data), 32'hA5);
        end
        m_ready = 1'b1;
        cyc();
        chk("bypass_drained", 32'(m_valid), 32'd0);

        // Fill with 0x01..0x07 offered, only five fit.
        m_ready = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            s_valid = 1'b1; s_data = 8'(i);
            cyc();
        end
        s_valid = 1'b0;
        chk("fill_count", 32'(count), 32'd5);
        chk("fill_ready", 32'(s_ready), 32'd0);
        m_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            chk("drain_data", 32'(m_data), 32'(i));
            cyc();
        end
        chk("drain_empty", 32'(m_valid), 32'd0);

        // Full with simultaneous write and read: the write is refused.
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            s_valid = 1'b1; s_data = 8'(i);
            cyc();
        end
        s_data = 8'h06; m_ready = 1'b1;
        cyc();
        s_valid = 1'b0; m_ready = 1'b0;
        chk("fullpop_count", 32'(count), 32'd4);
        chk("fullpop_ready", 32'(s_ready), 32'd1);
        chk("fullpop_data", 32'(m_data), 32'h02);
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) cyc();

        // Streaming 0x00..0xFF with both handshakes held high.
        s_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            s_data = 8'(i);
            cyc();
            chk("stream_data", 32'(m_data), 32'(i));
            chk("stream_count", 32'(count), 32'd1);
        end
        s_valid = 1'b0;
        cyc();

        // Random traffic with one reset injected at three words held.
        did_rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!did_rst && i > 50 && mq.size() == 3) begin
                did_rst = 1'b1;
                rst = 1'b1; s_valid = 1'($urandom); m_ready = 1'($urandom);
                cyc();
                rst = 1'b0;
                chk("midrst_count", 32'(count), 32'd0);
                chk("midrst_valid", 32'(m_valid), 32'd0);
                s_valid = 1'b1; s_data = 8'h3C; m_ready = 1'b0;
                cyc();
                chk("midrst_first", 32'(m_data), 32'h3C);
            end
            s_valid = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 2) != 0);
            s_data  = 8'($urandom);
            cyc();
        end
        chk("midrst_done", 32'(did_rst), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
